// File: rtl/freq_meter_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// freq_meter_ctrl : clear/gate/latch sequencer for a BCD frequency meter,
//                   overflow capture and free-running display digit scan.
// Revision 1.0
// ============================================================================
module freq_meter_ctrl #(
  parameter int GATE_CYCLES = 1000,
  parameter int HOLD_CYCLES = 500,
  parameter int SCAN_DIV    = 250,
  parameter int DIGITS      = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic              ovf_in,
  output logic              cnt_clear,
  output logic              gate,
  output logic              latch_load,
  output logic              done,
  output logic              ovf_flag,
  output logic              busy,
  output logic [DIGITS-1:0] digit_sel
);

  localparam int GW = $clog2(GATE_CYCLES + 1);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam int SW = $clog2(SCAN_DIV + 1);

  localparam logic [GW-1:0] C_GATE_LAST   = GW'(GATE_CYCLES - 1);
  localparam logic [HW-1:0] C_HOLD_LAST   = HW'(HOLD_CYCLES - 1);
  localparam logic [SW-1:0] C_SCAN_LAST   = SW'(SCAN_DIV - 1);
  localparam logic [1:0]    C_SETTLE_LAST = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_GATE   = 3'd2,
    S_SETTLE = 3'd3,
    S_LATCH  = 3'd4,
    S_HOLD   = 3'd5
  } state_t;

  state_t          r_state;
  logic [GW-1:0]   r_gate_timer;
  logic [HW-1:0]   r_hold_timer;
  logic [1:0]      r_settle_timer;
  logic [SW-1:0]   r_scan_timer;
  logic            r_ovf_sync1;
  logic            r_ovf_sync2;
  logic            r_ovf_prev;
  logic            r_ovf_pend;
  logic            w_ovf_rise;

  // ovf_in comes from the counter clock domain
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ovf_sync1 <= 1'b0;
      r_ovf_sync2 <= 1'b0;
      r_ovf_prev  <= 1'b0;
    end else begin
      r_ovf_sync1 <= ovf_in;
      r_ovf_sync2 <= r_ovf_sync1;
      r_ovf_prev  <= r_ovf_sync2;
    end
  end

  assign w_ovf_rise = r_ovf_sync2 & ~r_ovf_prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= S_IDLE;
      cnt_clear      <= 1'b0;
      gate           <= 1'b0;
      latch_load     <= 1'b0;
      done           <= 1'b0;
      ovf_flag       <= 1'b0;
      busy           <= 1'b0;
      r_gate_timer   <= '0;
      r_hold_timer   <= '0;
      r_settle_timer <= '0;
      r_ovf_pend     <= 1'b0;
    end else begin
      cnt_clear  <= 1'b0;
      latch_load <= 1'b0;
      done       <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (run) begin
            r_state   <= S_CLEAR;
            cnt_clear <= 1'b1;
            busy      <= 1'b1;
          end
        end
        S_CLEAR: begin
          r_ovf_pend   <= 1'b0;
          gate         <= 1'b1;
          r_gate_timer <= '0;
          r_state      <= S_GATE;
        end
        S_GATE: begin
          if (w_ovf_rise) r_ovf_pend <= 1'b1;
          if (r_gate_timer == C_GATE_LAST) begin
            gate           <= 1'b0;
            r_settle_timer <= '0;
            r_state        <= S_SETTLE;
          end else begin
            r_gate_timer <= r_gate_timer + 1'b1;
          end
        end
        // settle window also absorbs the synchronizer delay of late carries
        S_SETTLE: begin
          if (w_ovf_rise) r_ovf_pend <= 1'b1;
          if (r_settle_timer == C_SETTLE_LAST) begin
            latch_load <= 1'b1;
            done       <= 1'b1;
            r_state    <= S_LATCH;
          end else begin
            r_settle_timer <= r_settle_timer + 1'b1;
          end
        end
        S_LATCH: begin
          ovf_flag     <= r_ovf_pend;
          r_hold_timer <= '0;
          r_state      <= S_HOLD;
        end
        S_HOLD: begin
          if (r_hold_timer == C_HOLD_LAST) begin
            if (run) begin
              r_state   <= S_CLEAR;
              cnt_clear <= 1'b1;
            end else begin
              r_state <= S_IDLE;
              busy    <= 1'b0;
            end
          end else begin
            r_hold_timer <= r_hold_timer + 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          gate    <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_scan_timer <= '0;
      digit_sel    <= {{(DIGITS-1){1'b0}}, 1'b1};
    end else if (r_scan_timer == C_SCAN_LAST) begin
      r_scan_timer <= '0;
      digit_sel    <= {digit_sel[DIGITS-2:0], digit_sel[DIGITS-1]};
    end else begin
      r_scan_timer <= r_scan_timer + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_freq_meter_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_freq_meter_ctrl : randomized and directed bench with a timeline model.
// Revision 1.0
// ============================================================================
module tb_freq_meter_ctrl;

  localparam int G = 8;
  localparam int H = 4;
  localparam int S = 3;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         run = 1'b0;
  logic         ovf_in = 1'b0;
  logic         cnt_clear, gate, latch_load, done, ovf_flag, busy;
  logic [D-1:0] digit_sel;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  freq_meter_ctrl #(
    .GATE_CYCLES(G),
    .HOLD_CYCLES(H),
    .SCAN_DIV   (S),
    .DIGITS     (D)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .run       (run),
    .ovf_in    (ovf_in),
    .cnt_clear (cnt_clear),
    .gate      (gate),
    .latch_load(latch_load),
    .done      (done),
    .ovf_flag  (ovf_flag),
    .busy      (busy),
    .digit_sel (digit_sel)
  );

  // Model: m_p = cycles since run was accepted (-1 = idle), m_cyc = edges since reset
  int m_p = -1;
  int m_cyc = 0;
  bit m_pend = 1'b0;
  bit m_flag = 1'b0;
  bit q0 = 1'b0, q1 = 1'b0, q2 = 1'b0;

  always @(posedge clk or posedge reset) begin : b_model
    int old;
    bit det;
    bit npend;
    if (reset) begin
      m_p <= -1; m_cyc <= 0; m_pend <= 1'b0; m_flag <= 1'b0;
      q0 <= 1'b0; q1 <= 1'b0; q2 <= 1'b0;
    end else begin
      old   = m_p;
      det   = q1 & ~q2;
      npend = m_pend;
      if (det && old >= 1 && old <= G + 3) npend = 1'b1;
      if (old == 0) npend = 1'b0;
      m_pend <= npend;
      if (old == G + 4) m_flag <= m_pend;
      if (old < 0 || old == G + H + 4) m_p <= run ? 0 : -1;
      else m_p <= old + 1;
      m_cyc <= m_cyc + 1;
      q2 <= q1; q1 <= q0; q0 <= ovf_in;
    end
  end

  logic [9:0] dut_vec;
  logic [9:0] exp_vec;
  assign dut_vec = {cnt_clear, gate, latch_load, done, ovf_flag, busy, digit_sel};
  always_comb begin
    exp_vec = {m_p == 0, (m_p >= 1 && m_p <= G), m_p == G + 4, m_p == G + 4,
               m_flag, m_p >= 0, 4'(1 << ((m_cyc / S) % D))};
  end

  task automatic test_reset();
    run = 1'b0; ovf_in = 1'b0; reset = 1'b1;
    repeat (2) @(negedge clk);
    n_vec++;
    if (dut_vec !== 10'b00_0000_0001) begin
      n_err++; $display("FAIL reset_state: got %b expected %b", dut_vec, 10'b00_0000_0001);
    end
    reset = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      n_vec++;
      if (dut_vec !== exp_vec) begin
        n_err++; $display("FAIL idle_scan i=%0d: got %b expected %b", i, dut_vec, exp_vec);
      end
    end
  endtask

  task automatic test_single();
    int clears = 0, latches = 0;
    for (int i = 0; i < 25; i++) begin
      run = (i < 2);
      @(negedge clk);
      clears += int'(cnt_clear);
      latches += int'(latch_load);
      n_vec++;
      if (dut_vec !== exp_vec) begin
        n_err++; $display("FAIL single i=%0d: got %b expected %b", i, dut_vec, exp_vec);
      end
    end
    n_vec++;
    if (clears != 1 || latches != 1 || busy !== 1'b0) begin
      n_err++; $display("FAIL single_counts: got clears=%0d latches=%0d busy=%b expected 1 1 0",
                        clears, latches, busy);
    end
  endtask

  task automatic test_continuous();
    int clears = 0, latches = 0;
    for (int i = 0; i < 71; i++) begin
      run = (i < 51);
      @(negedge clk);
      if (i < 51) begin
        clears += int'(cnt_clear);
        latches += int'(latch_load);
      end
      n_vec++;
      if (dut_vec !== exp_vec) begin
        n_err++; $display("FAIL continuous i=%0d: got %b expected %b", i, dut_vec, exp_vec);
      end
    end
    n_vec++;
    if (clears != 3 || latches != 3) begin
      n_err++; $display("FAIL continuous_counts: got clears=%0d latches=%0d expected 3 3", clears, latches);
    end
  endtask

  task automatic test_ovf();
    for (int i = 0; i < 41; i++) begin
      run = (i < 19);
      ovf_in = (i == 6 || i == 7);
      @(negedge clk);
      n_vec++;
      if (dut_vec !== exp_vec) begin
        n_err++; $display("FAIL ovf i=%0d: got %b expected %b", i, dut_vec, exp_vec);
      end
      if (i == 16 || i == 29) begin
        n_vec++;
        if (ovf_flag !== 1'b1) begin
          n_err++; $display("FAIL ovf_set i=%0d: got %b expected 1", i, ovf_flag);
        end
      end
      if (i == 33) begin
        n_vec++;
        if (ovf_flag !== 1'b0) begin
          n_err++; $display("FAIL ovf_clear i=%0d: got %b expected 0", i, ovf_flag);
        end
      end
    end
  endtask

  task automatic test_ovf_ignored();
    for (int i = 0; i < 41; i++) begin
      run = (i < 2);
      ovf_in = (i == 14 || i == 15 || i == 25 || i == 26);
      @(negedge clk);
      n_vec++;
      if (dut_vec !== exp_vec) begin
        n_err++; $display("FAIL ovf_ignored i=%0d: got %b expected %b", i, dut_vec, exp_vec);
      end
    end
    n_vec++;
    if (ovf_flag !== 1'b0) begin
      n_err++; $display("FAIL ovf_ignored_flag: got %b expected 0", ovf_flag);
    end
  endtask

  task automatic test_reset_mid();
    int latches = 0;
    for (int i = 0; i < 6; i++) begin
      run = 1'b1;
      @(negedge clk);
      n_vec++;
      if (dut_vec !== exp_vec) begin
        n_err++; $display("FAIL pre_reset i=%0d: got %b expected %b", i, dut_vec, exp_vec);
      end
    end
    #2 reset = 1'b1;
    #1;
    n_vec++;
    if ({cnt_clear, gate, latch_load, done, busy} !== 5'b0) begin
      n_err++; $display("FAIL async_reset: got %b expected 00000",
                        {cnt_clear, gate, latch_load, done, busy});
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_vec++;
    if (cnt_clear !== 1'b1 || dut_vec !== exp_vec) begin
      n_err++; $display("FAIL restart_clear: got %b expected %b", dut_vec, exp_vec);
    end
    for (int i = 0; i < 45; i++) begin
      run = (i < 10);
      @(negedge clk);
      latches += int'(latch_load);
      n_vec++;
      if (dut_vec !== exp_vec) begin
        n_err++; $display("FAIL post_reset i=%0d: got %b expected %b", i, dut_vec, exp_vec);
      end
    end
    n_vec++;
    if (latches != 1) begin
      n_err++; $display("FAIL post_reset_latches: got %0d expected 1", latches);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 630; i++) begin
      if (i < 600) begin
        run = ($urandom_range(0, 9) < 7);
        if ($urandom_range(0, 7) == 0) ovf_in = ~ovf_in;
        reset = ($urandom_range(0, 149) == 0);
      end else begin
        run = 1'b0; ovf_in = 1'b0; reset = 1'b0;
      end
      @(negedge clk);
      n_vec++;
      if (dut_vec !== exp_vec) begin
        n_err++; $display("FAIL random i=%0d: got %b expected %b", i, dut_vec, exp_vec);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_continuous();
    test_ovf();
    test_ovf_ignored();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/freq_meter_ctrl.md
# freq_meter_ctrl

Measurement sequencer for the BCD frequency-meter datapath. It drives the clear, gate and latch strobes for the ripple chain of mod-10 digit counters and the per-digit result registers. It captures the overflow carry from the most significant digit. It also generates the one-hot digit-scan enable for the multiplexed 7-segment display.

## Interface
- GATE_CYCLES, 1000: gate-open window length in clk cycles (≥1)
- HOLD_CYCLES, 500: display-hold time after each latch, in clk cycles (≥1)
- SCAN_DIV, 250: clk cycles per display digit slot (≥1)
- DIGITS, 4: number of BCD digits scanned (≥2)

Ports:
- clk  in  1  system clock; all state changes on rising edge
- reset  in  1  asynchronous, active-high; forces every flop to its reset value immediately
- run  in  1  level; 1 = measure continuously, 0 = stop after the current measurement
- ovf_in  in  1  carry output of the most significant digit counter; asynchronous to clk
- cnt_clear  out  1  one-cycle pulse that clears the digit counter chain
- gate  out  1  high while input pulses may reach the counter chain
- latch_load  out  1  one-cycle load strobe for the result registers
- done  out  1  one-cycle pulse, coincident with latch_load
- ovf_flag  out  1  1 = the last latched result overflowed; updated only at latch
- busy  out  1  high in every state except IDLE
- digit_sel  out  DIGITS  one-hot display digit enable; bit 0 = least significant digit

## Operation
- Reset values: state IDLE, cnt_clear=0, gate=0, latch_load=0, done=0, ovf_flag=0, busy=0, digit_sel=1 (bit 0). All timers and synchronizer flops are 0.
- FSM states and transitions:
  - IDLE: all strobes 0. If run=1 at a rising edge, go to CLEAR.
  - CLEAR: cnt_clear=1 for exactly 1 cycle. Clear ovf_pend. Go to GATE.
  - GATE: gate=1 for exactly GATE_CYCLES cycles, counted by gate_timer (width $clog2(GATE_CYCLES+1)). Then go to SETTLE.
  - SETTLE: gate=0 for exactly 3 cycles. This lets the ripple chain settle and covers the synchronizer latency. Then go to LATCH.
  - LATCH: latch_load=1 and done=1 for 1 cycle. ovf_flag <= ovf_pend. Go to HOLD.
  - HOLD: lasts HOLD_CYCLES cycles. At the end, go to CLEAR if run=1, otherwise go to IDLE.
- run is sampled only in IDLE and on the last HOLD cycle. Deasserting run mid-measurement never aborts the measurement; it completes through HOLD.
- Overflow capture:
  - ovf_in passes through a 2-flop synchronizer, then a rising-edge detector.
  - Any detected rising edge while in GATE or SETTLE sets ovf_pend. ovf_pend is sticky until the next CLEAR.
  - Edges detected in other states are ignored.
- Display scan:
  - Free-running and independent of the FSM.
  - scan_timer counts 0..SCAN_DIV-1. On wrap, digit_sel rotates left by one: bit DIGITS-1 wraps to bit 0.
  - busy, run and the FSM state never stall the scan.
- Result registers capture on the falling clk edge. latch_load is a registered output, stable for a full cycle, so the capture falls mid-pulse.

## Timing
- run=1 sampled at edge N in IDLE: cnt_clear is high from N to N+1, and gate is high from N+1 to N+1+GATE_CYCLES.
- latch_load/done are high from edge N+GATE_CYCLES+4 to N+GATE_CYCLES+5.
- Continuous-mode period: GATE_CYCLES+HOLD_CYCLES+5 cycles from one cnt_clear to the next.
- ovf_in edge to ovf_pend set: 3 rising edges (2 sync + edge detect). An overflow in the last gate cycle is still captured within SETTLE.
- digit_sel changes every SCAN_DIV cycles. The first rotation occurs SCAN_DIV edges after reset release.
- Reset asserted mid-operation: immediate return to reset values, with no pending strobes. After release, run is re-evaluated in IDLE.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
Bench parameters: GATE_CYCLES=8, HOLD_CYCLES=4, SCAN_DIV=3, DIGITS=4.

1. Reset with run=0 for 20 cycles -> all outputs stay 0, busy=0. digit_sel is 0001, then 0010 at edge 3, 0100 at edge 6, 1000 at edge 9, 0001 at edge 12.
2. Assert run at edge 0, then deassert at edge 2 -> cnt_clear pulses during cycle 0–1. gate is high for edges 1–9. latch_load/done pulse during cycle 12–13. HOLD covers cycles 13–16, then IDLE with busy=0 and no second cnt_clear.
3. Hold run=1 continuously -> cnt_clear pulses every 17 cycles. Exactly one latch_load occurs per period.
4. Pulse ovf_in high for 2 cycles during the 5th gate cycle -> ovf_flag=1 after latch_load. In the next period with no ovf_in, ovf_flag returns to 0 at the next latch.
5. Pulse ovf_in during HOLD or IDLE only -> ovf_flag remains 0.
6. Assert reset during GATE (cycle 5) -> gate=0 immediately and no latch_load. With run=1 held, a fresh cnt_clear follows on the first edge after reset release.
